// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store memory access controller:
// operation and state encodings, lane widths and operation decode helpers.
package mem_access_ctrl_pkg;

  localparam int unsigned BYTE  = 8;
  localparam int unsigned HALF  = 16;
  localparam int unsigned WORD  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [OP_W-1:0] {
    LD_B  = 4'h0,
    LD_H  = 4'h1,
    LD_W  = 4'h2,
    LD_BU = 4'h4,
    LD_HU = 4'h5,
    ST_B  = 4'h8,
    ST_H  = 4'h9,
    ST_W  = 4'hA
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [WORD-1:0]   addr;
    logic [STRB_W-1:0] wstrb;
    logic [WORD-1:0]   wdata;
  } bus_cmd_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic op_store(input logic [OP_W-1:0] op);
    return (op == ST_B) || (op == ST_H) || (op == ST_W);
  endfunction

  function automatic logic op_misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
    case (op)
      LD_H, LD_HU, ST_H: return off[0];
      LD_W, ST_W:        return |off;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store strobe/data replication from the incoming
// request and load byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   st_op,
  input  logic [1:0]        st_off,
  input  logic [WORD-1:0]   st_data,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [WORD-1:0]   wdata_c,
  input  logic [OP_W-1:0]   ld_op,
  input  logic [1:0]        ld_off,
  input  logic [WORD-1:0]   ld_word,
  output logic [WORD-1:0]   rdata_c
);

  logic [BYTE-1:0] ld_byte;
  logic [HALF-1:0] ld_half;

  always_comb begin
    wstrb_c = '0;
    wdata_c = '0;
    case (st_op)
      ST_B: begin
        wstrb_c = 4'b0001 << st_off;
        wdata_c = {4{st_data[BYTE-1:0]}};
      end
      ST_H: begin
        wstrb_c = 4'b0011 << {st_off[1], 1'b0};
        wdata_c = {2{st_data[HALF-1:0]}};
      end
      ST_W: begin
        wstrb_c = 4'b1111;
        wdata_c = st_data;
      end
      default: ;
    endcase
  end

  // Stores and illegal ops yield zero so the response data is clean.
  always_comb begin
    ld_byte = BYTE'(ld_word >> {ld_off, 3'b000});
    ld_half = HALF'(ld_word >> {ld_off[1], 4'b0000});
    rdata_c = '0;
    case (ld_op)
      LD_B:  rdata_c = {{(WORD-BYTE){ld_byte[BYTE-1]}}, ld_byte};
      LD_BU: rdata_c = {{(WORD-BYTE){1'b0}}, ld_byte};
      LD_H:  rdata_c = {{(WORD-HALF){ld_half[HALF-1]}}, ld_half};
      LD_HU: rdata_c = {{(WORD-HALF){1'b0}}, ld_half};
      LD_W:  rdata_c = ld_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit bus controller: IDLE -> BUS -> RESP handshake with
// alignment checking. Optional bus-wait timeout enabled by MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [WORD-1:0]   req_addr,
  input  logic [WORD-1:0]   req_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [WORD-1:0]   bus_addr,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [WORD-1:0]   bus_wdata,
  input  logic              bus_ack,
  input  logic [WORD-1:0]   bus_rdata,
  output logic              rsp_valid,
  output logic [WORD-1:0]   rsp_rdata,
  output logic              rsp_ale,
  output logic              rsp_timeout
);

  state_e            state;
  bus_cmd_t          bus_q;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        off_q;
  logic [STRB_W-1:0] wstrb_c;
  logic [WORD-1:0]   wdata_c;
  logic [WORD-1:0]   rdata_c;
  logic              accept;

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] to_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign accept    = req_valid & req_ready;
  assign bus_we    = bus_q.we;
  assign bus_addr  = bus_q.addr;
  assign bus_wstrb = bus_q.wstrb;
  assign bus_wdata = bus_q.wdata;

  mem_lane_align u_align (
    .st_op   (req_op),
    .st_off  (req_addr[1:0]),
    .st_data (req_wdata),
    .wstrb_c (wstrb_c),
    .wdata_c (wdata_c),
    .ld_op   (op_q),
    .ld_off  (off_q),
    .ld_word (bus_rdata),
    .rdata_c (rdata_c)
  );

  // Bus command is cleared on leaving BUS so strobes read zero outside it.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      op_q      <= '0;
      off_q     <= '0;
      bus_req   <= 1'b0;
      bus_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_ale   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            off_q     <= req_addr[1:0];
            req_ready <= 1'b0;
            if (!op_legal(req_op)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else if (op_misaligned(req_op, req_addr[1:0])) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_ale   <= 1'b1;
            end else begin
              state       <= BUS;
              bus_req     <= 1'b1;
              bus_q.we    <= op_store(req_op);
              bus_q.addr  <= {req_addr[WORD-1:2], 2'b00};
              bus_q.wstrb <= wstrb_c;
              bus_q.wdata <= wdata_c;
`ifdef MEM_TIMEOUT_EN
              to_cnt      <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            state     <= RESP;
            bus_req   <= 1'b0;
            bus_q     <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_c;
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state       <= RESP;
            bus_req     <= 1'b0;
            bus_q       <= '0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_ale   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          rsp_timeout <= 1'b0;
`endif
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
